alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the 8-bit combinational ALU. It performs single-cycle add, subtract, and logic operations, plus iterative divide and modulo through a shared restoring divider. Operands are accepted with a valid/ready handshake, and the result is held under output back-pressure. It sits between the operand register file and the writeback stage of the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).
- CNT_W, $clog2(WIDTH+1), width of the divider iteration counter (derived, not overridden).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- valid_in  input  1  operand bundle valid.
- ready_out  output  1  block can accept an operand bundle.
- A_in  input  WIDTH  operand A.
- B_in  input  WIDTH  operand B.
- C_in  input  1  carry-in; used by ADD only.
- Opcode_in  input  3  operation select.
- valid_out  output  1  result valid.
- ready_in  input  1  downstream accepts the result.
- Result_out  output  WIDTH  result.
- C_out  output  1  carry (ADD) or borrow (SUB); 0 for all other opcodes.
- Err_out  output  1  illegal opcode, or divide/modulo by zero.

Behaviour:
- Reset (asynchronous, any cycle including mid-division):
  - state goes to IDLE.
  - ready_out=1, valid_out=0, Result_out=0, C_out=0, Err_out=0.
  - The divider counter and partial remainder are cleared.
- Acceptance:
  - A bundle is accepted on a rising edge where valid_in & ready_out.
  - Operands and opcode are registered at that edge; later input changes are ignored.
- ready_out is 1 only in IDLE.
- State machine:
  - IDLE -> DONE on accept of a single-cycle opcode.
  - IDLE -> CALC on accept of DIV or MOD with B!=0.
  - IDLE -> DONE on accept of DIV or MOD with B==0.
  - CALC -> DONE after exactly WIDTH iterations.
  - DONE -> IDLE on ready_in=1.
- Latency, with accept at edge N:
  - Single-cycle ops: valid_out=1 from edge N+1.
  - DIV/MOD: valid_out=1 from edge N+1+WIDTH.
  - Divide-by-zero: valid_out=1 from edge N+1.
- Output hold: in DONE, Result_out, C_out, Err_out and valid_out are stable until the edge where ready_in=1. valid_out drops to 0 on that edge.
- Outputs outside DONE: valid_out=0, and Result_out, C_out, Err_out keep their last values.
- Opcodes (all arithmetic is modulo 2^WIDTH):
  - 000 ADD: {C_out,Result} = A + B + C_in.
  - 001 SUB: Result = A - B; C_out = 1 iff A < B (borrow); C_in ignored.
  - 010 AND; 011 OR; 101 XOR.
  - 100 MOD: Result = A % B.
  - 110 DIV: Result = A / B.
  - 111 illegal: Result=0, C_out=0, Err_out=1.
- Zero divisor:
  - MOD with B==0: Result=A, Err_out=1.
  - DIV with B==0: Result=all ones, Err_out=1.
- Err_out=0 for every other case.
- Divider:
  - Restoring, one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits wide.
  - The counter counts from WIDTH down to 0.
- Simultaneous events:
  - valid_in while not in IDLE is ignored (ready_out=0); nothing is queued.
  - ready_in while valid_out=0 has no effect.

Decomposition:
- Package alu_seq_pkg:
  - opcode_t enum: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOD, OP_XOR, OP_DIV, OP_ILL.
  - state_t enum: IDLE, CALC, DONE.
- Sub-module alu_div_iter:
  - Parametrised by WIDTH.
  - Ports: start, dividend, divisor, busy, done, quotient, remainder.
  - Shared by DIV and MOD; alu_seq selects the quotient or remainder.

Test Plan:
1. WIDTH=8, ADD:
   - A=FE, B=01, C_in=1 -> one cycle after accept: Result=00, C_out=1, Err_out=0.
   - Hold ready_in=0 for 3 cycles -> outputs stable, ready_out=0.
2. WIDTH=8, SUB:
   - A=FF, B=01 -> Result=FE, C_out=0.
   - A=01, B=02 -> Result=FF, C_out=1.
3. WIDTH=8, MOD: A=10, B=3 -> valid_out exactly 9 edges after accept, Result=01.
4. WIDTH=8, DIV:
   - A=200, B=7 -> valid_out 9 edges after accept, Result=28.
   - valid_in pulses during CALC are not accepted.
5. WIDTH=8, boundaries:
   - DIV A=5, B=0 -> Result=FF, Err_out=1 at latency 1.
   - MOD A=5, B=0 -> Result=05, Err_out=1 at latency 1.
   - Opcode 111 -> Result=00, C_out=0, Err_out=1.
6. WIDTH=16, reset and recovery:
   - Assert rst_in 5 cycles into DIV A=FFFF, B=0003 -> immediately ready_out=1, valid_out=0, Result_out=0.
   - Next DIV A=FFFF, B=0003 -> Result=5555 at latency 17.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential ALU.
//   opcode_t : 3-bit operation select carried on Opcode_in
//   state_t  : control states of the ALU sequencer
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MOD = 3'b100,
    OP_XOR = 3'b101,
    OP_DIV = 3'b110,
    OP_ILL = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle of the sequential ALU.
//   valid_in/ready_out  : operand bundle handshake (A_in, B_in, C_in, Opcode_in)
//   valid_out/ready_in  : result handshake (Result_out, C_out, Err_out)
//   slave modport       : ALU side; master modport : requester/writeback side
interface alu_seq_if #(parameter int WIDTH = 8);

  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             C_in;
  logic [2:0]       Opcode_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] Result_out;
  logic             C_out;
  logic             Err_out;

  modport slave (
    input  valid_in, A_in, B_in, C_in, Opcode_in, ready_in,
    output ready_out, valid_out, Result_out, C_out, Err_out
  );

  modport master (
    output valid_in, A_in, B_in, C_in, Opcode_in, ready_in,
    input  ready_out, valid_out, Result_out, C_out, Err_out
  );

endinterface

// File: rtl/alu_div_iter.sv
// alu_div_iter: restoring divider, one quotient bit per cycle, MSB first.
//   clk, rst  : clock and asynchronous active-high reset
//   start     : load dividend/divisor and begin WIDTH iterations
//   dividend  : numerator, divisor : denominator (must be non-zero)
//   busy      : an operation is in progress
//   done      : one-cycle strobe; quotient/remainder are final
//   quotient, remainder : results, valid while done is high and until next start
module alu_div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             running_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Bring down the next dividend bit (held in the quotient register MSB) and
  // trial-subtract; a negative difference means the remainder is restored.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {2'b00, div_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
    end else if (start) begin
      cnt_q     <= CNT_W'(WIDTH);
      running_q <= 1'b1;
      rem_q     <= '0;
      quo_q     <= dividend;
      div_q     <= divisor;
    end else if (running_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (diff[WIDTH+1]) begin
          rem_q <= shifted[WIDTH:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_q <= diff[WIDTH:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        running_q <= 1'b0;
      end
    end
  end

  // done is raised for the cycle after the last iteration, so the consumer
  // sees exactly one strobe per operation.
  assign busy      = running_q;
  assign done      = running_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q[WIDTH-1:0];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes on both sides.
//   clk_in, rst_in : clock and asynchronous active-high reset
//   bus (slave)    : operands A_in/B_in/C_in/Opcode_in with valid_in/ready_out;
//                    Result_out/C_out/Err_out with valid_out/ready_in
// Single-cycle ops complete one edge after accept; DIV/MOD with a non-zero
// divisor run through alu_div_iter and complete WIDTH+1 edges after accept.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  alu_seq_if.slave   bus
);

  state_t           state_q, state_d;
  opcode_t          op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  opcode_t          opcode_in;
  logic             ready_int;
  logic             accept;
  logic [WIDTH:0]   add_sum;

  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk_in),
    .rst       (rst_in),
    .start     (div_start),
    .dividend  (bus.A_in),
    .divisor   (bus.B_in),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign opcode_in = opcode_t'(bus.Opcode_in);
  assign ready_int = (state_q == IDLE) && !div_busy;
  assign accept    = bus.valid_in && ready_int;
  assign add_sum   = {1'b0, bus.A_in} + {1'b0, bus.B_in} + {{WIDTH{1'b0}}, bus.C_in};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      result_q <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
    end
  end

  // Result registers change only on the transition into DONE, so the outputs
  // keep their last values while idle or dividing.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    result_d  = result_q;
    cout_d    = cout_q;
    err_d     = err_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DONE;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          case (opcode_in)
            OP_ADD: {cout_d, result_d} = add_sum;
            OP_SUB: begin
              result_d = bus.A_in - bus.B_in;
              cout_d   = bus.A_in < bus.B_in;
            end
            OP_AND: result_d = bus.A_in & bus.B_in;
            OP_OR:  result_d = bus.A_in | bus.B_in;
            OP_XOR: result_d = bus.A_in ^ bus.B_in;
            OP_MOD, OP_DIV: begin
              if (bus.B_in == '0) begin
                result_d = (opcode_in == OP_DIV) ? '1 : bus.A_in;
                err_d    = 1'b1;
              end else begin
                state_d   = CALC;
                op_d      = opcode_in;
                div_start = 1'b1;
                cout_d    = cout_q;
                err_d     = err_q;
              end
            end
            default: begin
              result_d = '0;
              err_d    = 1'b1;
            end
          endcase
        end
      end
      CALC: begin
        if (div_done) begin
          state_d  = DONE;
          result_d = (op_q == OP_DIV) ? div_quo : div_rem;
          cout_d   = 1'b0;
          err_d    = 1'b0;
        end
      end
      DONE: begin
        if (bus.ready_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_out  = ready_int;
  assign bus.valid_out  = (state_q == DONE);
  assign bus.Result_out = result_q;
  assign bus.C_out      = cout_q;
  assign bus.Err_out    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16.
// Expected results and latencies are pushed when a bundle is accepted and
// popped when the matching DUT instance raises valid_out.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int PERIOD = 10;

  typedef struct {
    string       tag;
    logic [15:0] result;
    logic        cout;
    logic        err;
    int          latency;
    time         acceptTime;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #(PERIOD/2) clk = ~clk;

  alu_seq_if #(.WIDTH(8))  bus8();
  alu_seq_if #(.WIDTH(16)) bus16();

  alu_seq #(.WIDTH(8))  dut8  (.clk_in(clk), .rst_in(rst), .bus(bus8.slave));
  alu_seq #(.WIDTH(16)) dut16 (.clk_in(clk), .rst_in(rst), .bus(bus16.slave));

  // Single comparison point: counts the vector and reports any miscompare.
  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic sampleOut(input bit is16, output logic valid, output logic ready,
                           output logic [15:0] result, output logic cout, output logic err);
    if (is16) begin
      valid = bus16.valid_out; ready = bus16.ready_out;
      result = bus16.Result_out; cout = bus16.C_out; err = bus16.Err_out;
    end else begin
      valid = bus8.valid_out; ready = bus8.ready_out;
      result = {8'h00, bus8.Result_out}; cout = bus8.C_out; err = bus8.Err_out;
    end
  endtask

  // Drive one bundle, wait for the accepting edge, then scramble the inputs.
  task automatic applyStimulus(input bit is16, input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic cin, input string tag,
                               input logic [15:0] expResult, input logic expC, input logic expErr,
                               input int expLat, input bit push);
    logic v, r, c, e;
    logic [15:0] res;
    exp_t item;
    @(negedge clk);
    sampleOut(is16, v, r, res, c, e);
    compare({tag, ".readyBefore"}, 32'(r), 32'd1);
    if (is16) begin
      bus16.valid_in = 1'b1; bus16.Opcode_in = op; bus16.A_in = a; bus16.B_in = b; bus16.C_in = cin;
    end else begin
      bus8.valid_in = 1'b1; bus8.Opcode_in = op; bus8.A_in = a[7:0]; bus8.B_in = b[7:0]; bus8.C_in = cin;
    end
    @(posedge clk);
    item.tag = tag; item.result = expResult; item.cout = expC; item.err = expErr;
    item.latency = expLat; item.acceptTime = $time;
    if (push) sb.push_back(item);
    #1;
    if (is16) begin
      bus16.valid_in = 1'b0; bus16.A_in = 16'($urandom); bus16.B_in = 16'($urandom);
      bus16.C_in = 1'($urandom); bus16.Opcode_in = 3'($urandom);
    end else begin
      bus8.valid_in = 1'b0; bus8.A_in = 8'($urandom); bus8.B_in = 8'($urandom);
      bus8.C_in = 1'($urandom); bus8.Opcode_in = 3'($urandom);
    end
  endtask

  // Wait (bounded) for valid_out, check against the scoreboard head, hold the
  // result for holdCycles with ready_in low, then release it.
  task automatic checkOutput(input bit is16, input int holdCycles);
    exp_t e;
    bit seen = 0;
    time edgeT = 0;
    logic v, r, c, er;
    logic [15:0] res;
    compare("sb.notEmpty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      edgeT = $time;
      #1;
      sampleOut(is16, v, r, res, c, er);
      if (v === 1'b1) seen = 1;
    end
    compare({e.tag, ".validSeen"}, 32'(seen), 32'd1);
    if (!seen) return;
    compare({e.tag, ".latency"}, 32'(int'((edgeT - e.acceptTime) / PERIOD)), 32'(e.latency));
    compare({e.tag, ".result"}, 32'(res), 32'(e.result));
    compare({e.tag, ".cout"}, 32'(c), 32'(e.cout));
    compare({e.tag, ".err"}, 32'(er), 32'(e.err));
    compare({e.tag, ".readyInDone"}, 32'(r), 32'd0);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      sampleOut(is16, v, r, res, c, er);
      compare({e.tag, ".holdValid"}, 32'(v), 32'd1);
      compare({e.tag, ".holdReady"}, 32'(r), 32'd0);
      compare({e.tag, ".holdOut"}, {14'd0, c, er, res}, {14'd0, e.cout, e.err, e.result});
    end
    if (is16) bus16.ready_in = 1'b1; else bus8.ready_in = 1'b1;
    @(posedge clk); #1;
    if (is16) bus16.ready_in = 1'b0; else bus8.ready_in = 1'b0;
    sampleOut(is16, v, r, res, c, er);
    compare({e.tag, ".validDrop"}, 32'(v), 32'd0);
    compare({e.tag, ".readyBack"}, 32'(r), 32'd1);
    compare({e.tag, ".keepOut"}, {14'd0, c, er, res}, {14'd0, e.cout, e.err, e.result});
  endtask

  initial begin
    logic v, r, c, er;
    logic [15:0] res;
    rst = 1'b1;
    bus8.valid_in = 1'b0; bus8.ready_in = 1'b0; bus8.A_in = '0; bus8.B_in = '0;
    bus8.C_in = 1'b0; bus8.Opcode_in = '0;
    bus16.valid_in = 1'b0; bus16.ready_in = 1'b0; bus16.A_in = '0; bus16.B_in = '0;
    bus16.C_in = 1'b0; bus16.Opcode_in = '0;
    repeat (2) @(negedge clk);
    sampleOut(0, v, r, res, c, er);
    compare("w8.reset", {27'd0, v, r, c, er, 1'b0}, {27'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    compare("w8.resetResult", 32'(res), 32'd0);
    sampleOut(1, v, r, res, c, er);
    compare("w16.reset", {27'd0, v, r, c, er, 1'b0}, {27'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    compare("w16.resetResult", 32'(res), 32'd0);
    rst = 1'b0;

    $display("[TB] WIDTH=8 single-cycle operations");
    applyStimulus(0, OP_ADD, 16'h00FE, 16'h0001, 1'b1, "add.wrap", 16'h0000, 1'b1, 1'b0, 1, 1);
    checkOutput(0, 3);
    applyStimulus(0, OP_SUB, 16'h00FF, 16'h0001, 1'b0, "sub.noBorrow", 16'h00FE, 1'b0, 1'b0, 1, 1);
    checkOutput(0, 0);
    applyStimulus(0, OP_SUB, 16'h0001, 16'h0002, 1'b1, "sub.borrow", 16'h00FF, 1'b1, 1'b0, 1, 1);
    checkOutput(0, 0);
    applyStimulus(0, OP_AND, 16'h00F0, 16'h003C, 1'b1, "and", 16'h0030, 1'b0, 1'b0, 1, 1);
    checkOutput(0, 0);
    applyStimulus(0, OP_OR, 16'h00F0, 16'h003C, 1'b1, "or", 16'h00FC, 1'b0, 1'b0, 1, 1);
    checkOutput(0, 0);
    applyStimulus(0, OP_XOR, 16'h00F0, 16'h003C, 1'b0, "xor", 16'h00CC, 1'b0, 1'b0, 1, 1);
    checkOutput(0, 1);

    $display("[TB] WIDTH=8 divider operations");
    applyStimulus(0, OP_MOD, 16'd10, 16'd3, 1'b0, "mod.10by3", 16'h0001, 1'b0, 1'b0, 9, 1);
    checkOutput(0, 1);
    applyStimulus(0, OP_DIV, 16'd200, 16'd7, 1'b0, "div.200by7", 16'd28, 1'b0, 1'b0, 9, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare("div.calcReady", 32'(bus8.ready_out), 32'd0);
      bus8.valid_in = 1'b1; bus8.Opcode_in = OP_ADD; bus8.A_in = 8'h01; bus8.B_in = 8'h01;
      @(negedge clk);
      bus8.valid_in = 1'b0;
    end
    checkOutput(0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compare("div.nothingQueued", 32'(bus8.valid_out), 32'd0);
    end

    $display("[TB] WIDTH=8 boundaries");
    applyStimulus(0, OP_DIV, 16'd5, 16'd0, 1'b0, "div.byZero", 16'h00FF, 1'b0, 1'b1, 1, 1);
    checkOutput(0, 0);
    applyStimulus(0, OP_MOD, 16'd5, 16'd0, 1'b0, "mod.byZero", 16'h0005, 1'b0, 1'b1, 1, 1);
    checkOutput(0, 0);
    applyStimulus(0, 3'b111, 16'h0012, 16'h0034, 1'b1, "illegal", 16'h0000, 1'b0, 1'b1, 1, 1);
    checkOutput(0, 0);
    applyStimulus(0, OP_ADD, 16'h00FF, 16'h00FF, 1'b1, "add.max", 16'h00FF, 1'b1, 1'b0, 1, 1);
    checkOutput(0, 0);

    $display("[TB] WIDTH=16 reset and recovery");
    applyStimulus(1, OP_ADD, 16'h1234, 16'h1111, 1'b0, "w16.add", 16'h2345, 1'b0, 1'b0, 1, 1);
    checkOutput(1, 0);
    applyStimulus(1, OP_DIV, 16'hFFFF, 16'h0003, 1'b0, "w16.divAbort", 16'h0000, 1'b0, 1'b0, 17, 0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sampleOut(1, v, r, res, c, er);
    compare("w16.abortReady", 32'(r), 32'd1);
    compare("w16.abortValid", 32'(v), 32'd0);
    compare("w16.abortResult", 32'(res), 32'd0);
    compare("w16.abortFlags", {30'd0, c, er}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, OP_DIV, 16'hFFFF, 16'h0003, 1'b0, "w16.div", 16'h5555, 1'b0, 1'b0, 17, 1);
    checkOutput(1, 2);
    applyStimulus(1, OP_MOD, 16'hFFFF, 16'h0007, 1'b0, "w16.mod", 16'h0001, 1'b0, 1'b0, 17, 1);
    checkOutput(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
